stopwatch_ctrl: RTL and testbench

- Central controller for the stopwatch/timer.
- Turns debounced button and switch levels, plus a 1 Hz tick, into pulses that sequence the mm:ss counter datapath:
  - count enable and direction
  - clear
  - minute/second adjust, with auto-repeat while a button is held
- Also drives alarm and display-blink status.
- Sits between the button debouncers/prescaler and the BCD time counter that feeds the 7-segment mux.

---
 rtl/stopwatch_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch/timer controller: button edges, 1 Hz tick and zero/max flags -> counter, adjust, alarm, blink.
// Latency: button acts 1 edge after it is sampled, tick/zero/max act on the sampling edge; no backpressure.
module stopwatch_ctrl #(
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 10_000_000,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       softrst_btn,
  input  logic       inc_min_btn,
  input  logic       inc_sec_btn,
  input  logic       mode_sw,
  input  logic       inc_sw,
  input  logic       time_zero,
  input  logic       time_max,
  output logic       cnt_en,
  output logic       cnt_down,
  output logic       cnt_clr,
  output logic       adj_min,
  output logic       adj_sec,
  output logic       adj_dn,
  output logic [1:0] state,
  output logic       alarm,
  output logic       disp_on
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam int AW      = $clog2(ALARM_SECS + 1);

  // bit order: {inc_sec, inc_min, softrst, stop, start}
  logic [4:0] btn_q;
  logic [4:0] btn_p;
  logic [4:0] btn_e;
  logic       start_e, stop_e, soft_e, min_e, sec_e;
  logic       min_q, sec_q;

  assign btn_e   = btn_q & ~btn_p;
  assign start_e = btn_e[0];
  assign stop_e  = btn_e[1];
  assign soft_e  = btn_e[2];
  assign min_e   = btn_e[3];
  assign sec_e   = btn_e[4];
  assign min_q   = btn_q[3];
  assign sec_q   = btn_q[4];

  logic [1:0]    state_n;
  logic          cnt_down_n, disp_on_n, cnt_en_n, cnt_clr_n, go_run;
  logic [AW-1:0] alarm_cnt, alarm_cnt_n;

  always_comb begin
    state_n     = state;
    cnt_down_n  = cnt_down;
    disp_on_n   = disp_on;
    alarm_cnt_n = alarm_cnt;
    cnt_en_n    = 1'b0;
    cnt_clr_n   = 1'b0;
    go_run      = 1'b0;
    case (state)
      S_IDLE: begin
        disp_on_n   = 1'b1;
        alarm_cnt_n = '0;
        if (soft_e) begin
          cnt_clr_n = 1'b1;
        end else if (start_e && !(mode_sw && time_zero)) begin
          state_n    = S_RUN;
          cnt_down_n = mode_sw;
          go_run     = 1'b1;
        end
      end
      S_RUN: begin
        if (soft_e) begin
          cnt_clr_n = 1'b1;
          state_n   = S_IDLE;
        end else if (stop_e) begin
          state_n   = S_PAUSE;
          disp_on_n = 1'b1;
        end else if (cnt_down && time_zero) begin
          state_n     = S_DONE;
          disp_on_n   = 1'b1;
          alarm_cnt_n = '0;
        end else if (tick_1hz) begin
          // a stopwatch at 99:59 stops instead of wrapping
          if (!cnt_down && time_max) begin
            state_n     = S_DONE;
            disp_on_n   = 1'b1;
            alarm_cnt_n = '0;
          end else begin
            cnt_en_n = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (soft_e) begin
          cnt_clr_n = 1'b1;
          state_n   = S_IDLE;
          disp_on_n = 1'b1;
        end else if (start_e) begin
          state_n   = S_RUN;
          disp_on_n = 1'b1;
        end else if (tick_1hz) begin
          disp_on_n = ~disp_on;
        end
      end
      default: begin
        if (soft_e || start_e || stop_e) begin
          cnt_clr_n   = soft_e;
          state_n     = S_IDLE;
          disp_on_n   = 1'b1;
          alarm_cnt_n = '0;
        end else if (tick_1hz) begin
          if (alarm_cnt == AW'(ALARM_SECS - 1)) begin
            state_n     = S_IDLE;
            disp_on_n   = 1'b1;
            alarm_cnt_n = '0;
          end else begin
            alarm_cnt_n = alarm_cnt + AW'(1);
            disp_on_n   = ~disp_on;
          end
        end
      end
    endcase
  end

  // Auto-repeat: phase 0 waits RPT_DELAY after the first pulse, phase 1 spaces by RPT_PERIOD.
  logic [RW-1:0] min_cnt, min_cnt_n, sec_cnt, sec_cnt_n;
  logic          min_ph, min_ph_n, sec_ph, sec_ph_n;
  logic          min_fire, sec_fire, adj_act;

  assign adj_act = (state == S_IDLE) && !go_run;

  always_comb begin
    min_cnt_n = '0;
    min_ph_n  = 1'b0;
    min_fire  = 1'b0;
    if (adj_act && min_q) begin
      if (min_e) begin
        min_fire  = 1'b1;
        min_cnt_n = RW'(1);
      end else if (min_cnt == (min_ph ? RW'(RPT_PERIOD) : RW'(RPT_DELAY))) begin
        min_fire  = 1'b1;
        min_cnt_n = RW'(1);
        min_ph_n  = 1'b1;
      end else begin
        min_cnt_n = min_cnt + RW'(1);
        min_ph_n  = min_ph;
      end
    end
  end

  // minutes take precedence; seconds stay parked at zero while minutes are held
  always_comb begin
    sec_cnt_n = '0;
    sec_ph_n  = 1'b0;
    sec_fire  = 1'b0;
    if (adj_act && sec_q && !min_q) begin
      if (sec_e) begin
        sec_fire  = 1'b1;
        sec_cnt_n = RW'(1);
      end else if (sec_cnt == (sec_ph ? RW'(RPT_PERIOD) : RW'(RPT_DELAY))) begin
        sec_fire  = 1'b1;
        sec_cnt_n = RW'(1);
        sec_ph_n  = 1'b1;
      end else begin
        sec_cnt_n = sec_cnt + RW'(1);
        sec_ph_n  = sec_ph;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q     <= '0;
      btn_p     <= '0;
      state     <= S_IDLE;
      cnt_down  <= 1'b0;
      disp_on   <= 1'b1;
      alarm_cnt <= '0;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      adj_min   <= 1'b0;
      adj_sec   <= 1'b0;
      adj_dn    <= 1'b0;
      min_cnt   <= '0;
      min_ph    <= 1'b0;
      sec_cnt   <= '0;
      sec_ph    <= 1'b0;
    end else begin
      btn_q     <= {inc_sec_btn, inc_min_btn, softrst_btn, stop_btn, start_btn};
      btn_p     <= btn_q;
      state     <= state_n;
      cnt_down  <= cnt_down_n;
      disp_on   <= disp_on_n;
      alarm_cnt <= alarm_cnt_n;
      cnt_en    <= cnt_en_n;
      cnt_clr   <= cnt_clr_n;
      adj_min   <= min_fire;
      adj_sec   <= sec_fire;
      adj_dn    <= (min_fire || sec_fire) ? inc_sw : 1'b0;
      min_cnt   <= min_cnt_n;
      min_ph    <= min_ph_n;
      sec_cnt   <= sec_cnt_n;
      sec_ph    <= sec_ph_n;
    end
  end

  assign alarm = (state == S_DONE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl; expected output events are queued and matched by a monitor.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_EN   = 4'b1000;
  localparam logic [3:0] P_CLR  = 4'b0100;
  localparam logic [3:0] P_AMIN = 4'b0010;
  localparam logic [3:0] P_ASEC = 4'b0001;

  localparam logic [4:0] B_START = 5'b00001;
  localparam logic [4:0] B_STOP  = 5'b00010;
  localparam logic [4:0] B_SOFT  = 5'b00100;
  localparam logic [4:0] B_MIN   = 5'b01000;
  localparam logic [4:0] B_SEC   = 5'b10000;

  localparam logic [9:0] RST_OBS = 10'b0000000100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [4:0] btns = '0;
  logic       mode_sw = 1'b0;
  logic       inc_sw = 1'b0;
  logic       time_zero = 1'b0;
  logic       time_max = 1'b0;
  logic       cnt_en, cnt_down, cnt_clr, adj_min, adj_sec, adj_dn, alarm, disp_on;
  logic [1:0] state;

  stopwatch_ctrl #(.RPT_DELAY(20), .RPT_PERIOD(5), .ALARM_SECS(3)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .start_btn(btns[0]), .stop_btn(btns[1]), .softrst_btn(btns[2]),
    .inc_min_btn(btns[3]), .inc_sec_btn(btns[4]),
    .mode_sw(mode_sw), .inc_sw(inc_sw), .time_zero(time_zero), .time_max(time_max),
    .cnt_en(cnt_en), .cnt_down(cnt_down), .cnt_clr(cnt_clr),
    .adj_min(adj_min), .adj_sec(adj_sec), .adj_dn(adj_dn),
    .state(state), .alarm(alarm), .disp_on(disp_on)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // [9] cnt_en [8] cnt_clr [7] adj_min [6] adj_sec [5] adj_dn [4] cnt_down [3] alarm [2] disp_on [1:0] state
  logic [9:0] obs;
  assign obs = {cnt_en, cnt_clr, adj_min, adj_sec, adj_dn, cnt_down, alarm, disp_on, state};

  typedef struct {
    int         cyc;
    logic [9:0] o;
  } ev_t;
  ev_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  task automatic exp_ev(input int at, input logic [3:0] p, input logic dn,
                        input logic [1:0] st, input logic cd, input logic dp);
    ev_t e;
    e.cyc = at;
    e.o   = {p, dn, cd, (st == S_DONE), dp, st};
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] m);
    btns = m;
    @(negedge clk);
    btns = '0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic drain(input string nm);
    step(30);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing events got=0 want=%0d (next at cyc %0d)", nm, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  // Monitor: every pulse or change of a steady output must match the head of the queue.
  initial begin
    logic [9:0] prv;
    ev_t        e;
    prv = RST_OBS;
    forever begin
      @(negedge clk);
      if (rst && mon_en && ((obs[9:6] != 4'b0000) || (obs[4:0] != prv[4:0]))) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected event cyc=%0d got=%b want=none", cyc, obs);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.o !== obs) begin
            errors++;
            $display("FAIL event got cyc=%0d %b want cyc=%0d %b", cyc, obs, e.cyc, e.o);
          end
        end
      end
      prv = obs;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset asserted before any clock edge must already show reset values
    #2 rst = 1'b0;
    #2 chk("reset_values", obs, RST_OBS);
    step(3);
    rst    = 1'b1;
    mon_en = 1'b1;
    step(5);

    // stopwatch run / pause / resume
    mode_sw = 1'b0;
    exp_ev(cyc + 2, P_NONE, 0, S_RUN, 0, 1); press(B_START); step(20);
    for (int i = 0; i < 3; i++) begin
      exp_ev(cyc + 1, P_EN, 0, S_RUN, 0, 1); tick(); step(99);
    end
    exp_ev(cyc + 2, P_NONE, 0, S_PAUSE, 0, 1); press(B_STOP); step(20);
    exp_ev(cyc + 1, P_NONE, 0, S_PAUSE, 0, 0); tick(); step(99);
    exp_ev(cyc + 1, P_NONE, 0, S_PAUSE, 0, 1); tick(); step(99);
    exp_ev(cyc + 2, P_NONE, 0, S_RUN, 0, 1); press(B_START); step(20);
    exp_ev(cyc + 1, P_EN, 0, S_RUN, 0, 1); tick(); step(20);
    exp_ev(cyc + 2, P_CLR, 0, S_IDLE, 0, 1); press(B_SOFT);
    drain("stopwatch");

    // timer counts down to zero, alarms, then times out to IDLE without clearing
    mode_sw = 1'b1;
    exp_ev(cyc + 2, P_NONE, 0, S_RUN, 1, 1); press(B_START); step(20);
    for (int i = 0; i < 5; i++) begin
      exp_ev(cyc + 1, P_EN, 0, S_RUN, 1, 1); tick();
      step((i < 4) ? 99 : 1);
    end
    exp_ev(cyc + 1, P_NONE, 0, S_DONE, 1, 1); time_zero = 1'b1; step(99);
    exp_ev(cyc + 1, P_NONE, 0, S_DONE, 1, 0); tick(); step(99);
    exp_ev(cyc + 1, P_NONE, 0, S_DONE, 1, 1); tick(); step(99);
    exp_ev(cyc + 1, P_NONE, 0, S_IDLE, 1, 1); tick();
    drain("timer_expiry");

    // timer start refused at 00:00; ticks in IDLE do nothing
    press(B_START); step(10); tick(); step(10); tick();
    drain("timer_at_zero");
    time_zero = 1'b0;

    // seconds auto-repeat, decrement direction
    inc_sw = 1'b1;
    begin
      int n;
      n = cyc;
      exp_ev(n + 2,  P_ASEC, 1, S_IDLE, 1, 1);
      exp_ev(n + 22, P_ASEC, 1, S_IDLE, 1, 1);
      exp_ev(n + 27, P_ASEC, 1, S_IDLE, 1, 1);
      exp_ev(n + 32, P_ASEC, 1, S_IDLE, 1, 1);
      exp_ev(n + 37, P_ASEC, 1, S_IDLE, 1, 1);
      btns = B_SEC; step(40); btns = '0;
    end
    drain("repeat_sec");

    // minutes pressed while seconds held: only minutes act afterwards
    inc_sw = 1'b0;
    begin
      int m;
      m = cyc;
      exp_ev(m + 2,  P_ASEC, 0, S_IDLE, 1, 1);
      exp_ev(m + 12, P_AMIN, 0, S_IDLE, 1, 1);
      exp_ev(m + 32, P_AMIN, 0, S_IDLE, 1, 1);
      exp_ev(m + 37, P_AMIN, 0, S_IDLE, 1, 1);
      btns = B_SEC; step(10);
      btns = B_SEC | B_MIN; step(30);
      btns = '0;
    end
    drain("repeat_both");

    // priority: softrst > stop > start; stopwatch stops at 99:59
    mode_sw = 1'b0;
    exp_ev(cyc + 2, P_NONE, 0, S_RUN, 0, 1); press(B_START); step(10);
    exp_ev(cyc + 2, P_CLR, 0, S_IDLE, 0, 1); press(B_START | B_STOP | B_SOFT); step(10);
    exp_ev(cyc + 2, P_NONE, 0, S_RUN, 0, 1); press(B_START); step(10);
    exp_ev(cyc + 2, P_NONE, 0, S_PAUSE, 0, 1); press(B_START | B_STOP); step(10);
    exp_ev(cyc + 2, P_CLR, 0, S_IDLE, 0, 1); press(B_SOFT); step(10);
    exp_ev(cyc + 2, P_NONE, 0, S_RUN, 0, 1); press(B_START); step(10);
    time_max = 1'b1;
    exp_ev(cyc + 1, P_NONE, 0, S_DONE, 0, 1); tick(); step(10);
    exp_ev(cyc + 2, P_NONE, 0, S_IDLE, 0, 1); press(B_STOP);
    time_max = 1'b0;
    drain("priority_max");

    // async reset mid-RUN, between clock edges, right while cnt_en is high
    mode_sw = 1'b1;
    exp_ev(cyc + 2, P_NONE, 0, S_RUN, 1, 1); press(B_START); step(10);
    exp_ev(cyc + 1, P_EN, 0, S_RUN, 1, 1); tick();
    #2;
    mon_en = 1'b0;
    rst    = 1'b0;
    #1 chk("async_reset", obs, RST_OBS);
    step(2);
    rst    = 1'b1;
    mon_en = 1'b1;
    drain("after_reset");
    chk("idle_after_reset", obs, RST_OBS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
